// File: rtl/serial_transducer_scheduler_pkg.sv
// rtl/serial_transducer_scheduler_pkg.sv - shared encodings and the Mealy transducer table
package serial_transducer_scheduler_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } xd_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } sched_state_e;

    // Returns {y, next_state} for one input bit.
    function automatic logic [2:0] xd_step(input xd_state_e s, input logic x);
        logic [2:0] r;
        case (s)
            S0:      r = x ? {1'b1, S0} : {1'b0, S1};
            S1:      r = x ? {1'b0, S3} : {1'b1, S2};
            S2:      r = x ? {1'b0, S1} : {1'b1, S0};
            S3:      r = x ? {1'b1, S2} : {1'b0, S3};
            default: r = {1'b0, S0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serial_transducer_scheduler_if.sv
// rtl/serial_transducer_scheduler_if.sv - requester-side bundle of the transducer scheduler
interface serial_transducer_scheduler_if #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   grant;
    logic           busy;
    logic           done;
    logic [IDW-1:0] done_id;
    logic [W-1:0]   result;

    modport master (
        output req, data_in,
        input  grant, busy, done, done_id, result
    );

    modport slave (
        input  req, data_in,
        output grant, busy, done, done_id, result
    );
endinterface

// File: rtl/serial_transducer_core.sv
// rtl/serial_transducer_core.sv - 4-state bit-serial Mealy transducer engine
module serial_transducer_core
    import serial_transducer_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic x,
    output logic y
);
    xd_state_e  state_q;
    logic [2:0] step;

    always_comb begin
        step = xd_step(state_q, x);
        y    = step[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else if (clear) begin
            state_q <= S0;
        end else if (en) begin
            state_q <= xd_state_e'(step[1:0]);
        end
    end
endmodule

// File: rtl/serial_transducer_scheduler.sv
// rtl/serial_transducer_scheduler.sv - round-robin sharing of one serial transducer among N requesters
module serial_transducer_scheduler
    import serial_transducer_scheduler_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = $clog2(N)
) (
    input logic clk,
    input logic rst,
    serial_transducer_scheduler_if.slave bus
);
    localparam int CW = $clog2(W);

    sched_state_e   state_q, state_d;
    logic [IDW-1:0] last_winner, pick;
    logic           found;
    logic [N-1:0]   grant_q;
    logic [W-1:0]   shreg, acc, acc_next, result_q;
    logic [CW-1:0]  cnt;
    logic           busy_q, done_q;
    logic [IDW-1:0] done_id_q;
    logic           core_clear, core_en, core_y;
    int             idx;

    // Scan starts just after the previous winner so every requester gets a turn.
    always_comb begin
        pick  = last_winner;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_winner) + k) % N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = SHIFT;
            SHIFT:   if (cnt == CW'(W - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign core_clear = (state_q == IDLE) && found;
    assign core_en    = (state_q == SHIFT);
    assign acc_next   = {acc[W-2:0], core_y};

    serial_transducer_core u_core (
        .clk   (clk),
        .rst   (rst),
        .clear (core_clear),
        .en    (core_en),
        .x     (shreg[W-1]),
        .y     (core_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_winner <= IDW'(N - 1);
            grant_q     <= '0;
            shreg       <= '0;
            acc         <= '0;
            cnt         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            result_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q     <= {{(N-1){1'b0}}, 1'b1} << pick;
                        last_winner <= pick;
                        shreg       <= bus.data_in[pick*W +: W];
                        acc         <= '0;
                        cnt         <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc   <= acc_next;
                    shreg <= shreg << 1;
                    cnt   <= cnt + CW'(1);
                    if (state_d == DONE) begin
                        done_q    <= 1'b1;
                        result_q  <= acc_next;
                        done_id_q <= last_winner;
                    end
                end
                DONE: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_serial_transducer_scheduler.sv
// tb/tb_serial_transducer_scheduler.sv - directed vector bench for serial_transducer_scheduler
module tb_serial_transducer_scheduler;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_transducer_scheduler_if #(.N(N), .W(W)) bus ();

    serial_transducer_scheduler #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         id;
        logic [7:0] word;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input int id, input logic [7:0] word, input logic [7:0] exp, input bit disturb);
        int n    = 0;
        bit seen = 0;
        @(negedge clk);
        bus.data_in = '0;
        bus.data_in[id*W +: W] = word;
        bus.req = 4'(1) << id;
        while (n < 30 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check($sformatf("grant_start_r%0d", id), 32'(bus.grant), 32'(1) << id);
                check($sformatf("busy_start_r%0d", id), 32'(bus.busy), 1);
            end
            if (disturb && n == 4) begin
                bus.data_in = ~bus.data_in;
                bus.req = '0;
            end
            if (bus.done) seen = 1;
        end
        check($sformatf("done_seen_r%0d", id), 32'(seen), 1);
        check($sformatf("done_latency_r%0d", id), 32'(n), W + 1);
        check($sformatf("done_id_r%0d", id), 32'(bus.done_id), 32'(id));
        check($sformatf("result_r%0d_w%0h", id, word), 32'(bus.result), 32'(exp));
        check($sformatf("grant_in_done_r%0d", id), 32'(bus.grant), 32'(1) << id);
        bus.req = '0;
        @(negedge clk);
        check($sformatf("done_pulse_end_r%0d", id), 32'(bus.done), 0);
        check($sformatf("grant_idle_r%0d", id), 32'(bus.grant), 0);
        check($sformatf("busy_idle_r%0d", id), 32'(bus.busy), 0);
        check($sformatf("result_hold_r%0d", id), 32'(bus.result), 32'(exp));
    endtask

    initial begin
        int         n;
        int         ndone;
        int         last_cyc;
        int         exp_id  [5];
        logic [7:0] exp_res [5];

        vecs[0] = '{0, 8'hFF, 8'hFF};
        vecs[1] = '{2, 8'h00, 8'h6D};
        vecs[2] = '{1, 8'h80, 8'hB6};
        vecs[3] = '{3, 8'h55, 8'h1C};
        vecs[4] = '{0, 8'hAA, 8'h8E};
        vecs[5] = '{2, 8'hF0, 8'hF6};
        vecs[6] = '{1, 8'h0F, 8'h64};
        vecs[7] = '{3, 8'h01, 8'h6C};

        rst = 1'b1;
        bus.req = '0;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        check("reset_grant", 32'(bus.grant), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_done_id", 32'(bus.done_id), 0);
        check("reset_result", 32'(bus.result), 0);
        rst = 1'b0;

        // All requesters active from reset: strict rotation starting at 0, one job per 10 cycles.
        exp_id  = '{0, 1, 2, 3, 0};
        exp_res = '{8'h1C, 8'h8E, 8'hF6, 8'h64, 8'h1C};
        bus.data_in = {8'h0F, 8'hF0, 8'hAA, 8'h55};
        bus.req = 4'b1111;
        n = 0;
        ndone = 0;
        last_cyc = 0;
        while (n < 80 && ndone < 5) begin
            @(negedge clk);
            n++;
            if (bus.done) begin
                check($sformatf("rot_id_%0d", ndone), 32'(bus.done_id), 32'(exp_id[ndone]));
                check($sformatf("rot_result_%0d", ndone), 32'(bus.result), 32'(exp_res[ndone]));
                if (ndone > 0)
                    check($sformatf("rot_period_%0d", ndone), 32'(n - last_cyc), W + 2);
                last_cyc = n;
                ndone++;
            end
        end
        check("rot_done_count", 32'(ndone), 5);
        bus.req = '0;
        @(negedge clk);
        check("rot_grant_idle", 32'(bus.grant), 0);

        for (int i = 0; i < 8; i++)
            run_job(vecs[i].id, vecs[i].word, vecs[i].exp, 1'b0);

        // data_in flipped and req dropped mid-job must not disturb the result.
        run_job(0, 8'h00, 8'h6D, 1'b1);

        // Async reset in the middle of a requester 3 job.
        @(negedge clk);
        bus.data_in = {8'hAA, 24'h0};
        bus.req = 4'b1000;
        repeat (5) @(negedge clk);
        check("mid_busy_before_rst", 32'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_grant", 32'(bus.grant), 0);
        check("rst_async_busy", 32'(bus.busy), 0);
        check("rst_async_result", 32'(bus.result), 0);
        check("rst_async_done", 32'(bus.done), 0);
        @(negedge clk);
        check("rst_held_done", 32'(bus.done), 0);
        bus.data_in = {8'hFF, 8'h00, 8'h00, 8'h80};
        bus.req = 4'b1001;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_grant", 32'(bus.grant), 32'b0001);
        n = 0;
        while (n < 30 && !bus.done) begin
            @(negedge clk);
            n++;
        end
        check("post_rst_done_seen", 32'(bus.done), 1);
        check("post_rst_done_id", 32'(bus.done_id), 0);
        check("post_rst_result", 32'(bus.result), 32'hB6);
        bus.req = '0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
